sys_bus_ic: RTL and testbench
=============================

SYS_BUS_IC -- requirements
Module: sys_bus_ic

Interface
REQ-001 SHALL have parameter N_MST, default 2, number of bus masters (1..8).
REQ-002 SHALL have parameter N_SLV, default 4, number of slave regions (1..16).
REQ-003 SHALL have parameter DW, default 32, data width; address width is fixed at 32.
REQ-004 SHALL have parameter SEL_LSB, default 28, LSB of the slave-select field adr[31:SEL_LSB].
REQ-005 SHALL have parameter TIMEOUT, default 255, max BUSY cycles without s_ready before abort (1..65535).
REQ-006 SHALL have ports clk input 1 (system clock) and rst_n input 1 (asynchronous, active-low reset); these are the block's only clock and reset.
REQ-007 SHALL have ports m_req input N_MST (per-master request), m_we input N_MST (per-master write enable), m_adr input 32*N_MST, m_wdata input DW*N_MST.
REQ-008 SHALL have ports m_gnt output N_MST (one-cycle accept pulse), m_rvalid output N_MST (one-cycle completion pulse), m_rdata output DW (shared read data), m_err output 1 (error flag, valid with m_rvalid).
REQ-009 SHALL have ports s_req output N_SLV (one-hot select), s_we output 1, s_adr output 32, s_wdata output DW (shared to all slaves).
REQ-010 SHALL have ports s_ready input N_SLV (slave done) and s_rdata input DW*N_SLV.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-012 In IDLE with any m_req high, SHALL pick the winner by round-robin starting at the index after the last granted master, then latch the winner index, adr, we and wdata at the clock edge.
REQ-013 SHALL pulse m_gnt[winner] for exactly the first cycle after the latching edge; the master holds req/adr/we/wdata stable until it sees m_gnt, and may drop them afterwards.
REQ-014 SHALL decode sel = adr[31:SEL_LSB]; if sel < N_SLV, go IDLE->BUSY; if sel >= N_SLV, go IDLE->RESP with decode error.
REQ-015 In BUSY, SHALL drive s_req[sel]=1 with the latched s_we/s_adr/s_wdata; all other s_req bits are 0.
REQ-016 In BUSY, on s_ready[sel]=1 at an edge, SHALL register s_rdata[sel] (reads) or 0 (writes) into m_rdata and go to RESP.
REQ-017 In RESP, SHALL assert m_rvalid[owner]=1 for one cycle with m_rdata and m_err valid, then return to IDLE.
REQ-018 Minimum latency: request sampled at edge 0, s_req high in cycle 1; if s_ready is high in cycle 1, m_rvalid is high in cycle 2.
REQ-019 SHALL ignore s_ready from unselected slaves and s_ready outside BUSY.
REQ-020 SHALL count BUSY cycles; if TIMEOUT cycles elapse without s_ready[sel], SHALL drop s_req, set m_err=1, set m_rdata=0 and go to RESP.
REQ-021 For a decode error, SHALL set m_err=1 and m_rdata=0 and never raise any s_req.
REQ-022 SHALL update the round-robin pointer to winner+1 (mod N_MST) on every grant, including errored transactions.
REQ-023 SHALL hold at most one outstanding transaction; new requests wait in IDLE and a request cannot be granted in RESP.
REQ-024 Outside RESP, m_rvalid SHALL be 0 and m_err 0; m_rdata SHALL hold its last value.

Reset
REQ-025 On rst_n low, SHALL immediately enter IDLE and set all of the following to 0: m_gnt, m_rvalid, m_err, m_rdata, s_req, s_we, s_adr, s_wdata, the timeout counter, and the RR pointer (master 0 has highest priority).
REQ-026 Reset during BUSY or RESP SHALL abort the transaction with no m_rvalid pulse.

Structure
REQ-027 State encodings and the TIMEOUT default SHALL live in the shared defines file, next to the existing TRUE/FALSE macros.
REQ-028 The round-robin arbiter SHALL be a sub-module rr_arbiter (N-bit request, pointer in, one-hot grant out).

Verification
REQ-029 Single read: master 0 reads 0x0000_0010 (sel 0), slave 0 ready in cycle 1 with 0xCAFE_F00D -> m_gnt[0] in cycle 1, m_rvalid[0] in cycle 2, m_rdata=0xCAFE_F00D, m_err=0.
REQ-030 Contention: m_req=2'b11 held continuously -> grants alternate 0,1,0,1; neither master waits more than one transaction.
REQ-031 Wait states: write 0x1234_5678 to 0x2000_0000, slave 2 raises ready after 5 cycles -> s_req[2] high for 5 cycles, s_wdata=0x1234_5678, m_rvalid after the 6th cycle, m_err=0.
REQ-032 Decode error: N_SLV=4, read 0x5000_0000 -> no s_req bit ever high, m_rvalid 1 cycle after m_gnt, m_err=1, m_rdata=0.
REQ-033 Timeout: TIMEOUT=8, slave 1 never ready -> s_req[1] high for exactly 8 cycles, then m_err=1 and m_rdata=0.
REQ-034 Reset mid-BUSY: rst_n low in cycle 3 of a wait -> all outputs 0 immediately, no m_rvalid; after release, the next m_req[1] is granted normally.

Source files
------------

// File: rtl/sys_bus_ic_pkg.sv
// Shared definitions for the system bus interconnect:
// truth constants, FSM state encoding, defaults and index helpers.
package sys_bus_ic_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int TIMEOUT_DEF = 255;

    // Index width that never collapses to zero bits for a single element.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sys_bus_ic_rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or above ptr wins,
// otherwise the search wraps to index 0.
module rr_arbiter
    import sys_bus_ic_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = FALSE;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                gnt[j] = TRUE;
                found  = TRUE;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                gnt[j] = TRUE;
                found  = TRUE;
            end
        end
    end

endmodule

// File: rtl/sys_bus_ic.sv
// Single-outstanding shared-bus interconnect: N_MST masters arbitrated
// round-robin onto N_SLV address-decoded slaves, with decode error and timeout.
module sys_bus_ic
    import sys_bus_ic_pkg::*;
#(
    parameter int N_MST   = 2,
    parameter int N_SLV   = 4,
    parameter int DW      = 32,
    parameter int SEL_LSB = 28,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_MST-1:0]    m_req,
    input  logic [N_MST-1:0]    m_we,
    input  logic [32*N_MST-1:0] m_adr,
    input  logic [DW*N_MST-1:0] m_wdata,
    output logic [N_MST-1:0]    m_gnt,
    output logic [N_MST-1:0]    m_rvalid,
    output logic [DW-1:0]       m_rdata,
    output logic                m_err,
    output logic [N_SLV-1:0]    s_req,
    output logic                s_we,
    output logic [31:0]         s_adr,
    output logic [DW-1:0]       s_wdata,
    input  logic [N_SLV-1:0]    s_ready,
    input  logic [DW*N_SLV-1:0] s_rdata
);

    localparam int MW = idx_w(N_MST);
    localparam int SW = idx_w(N_SLV);

    state_e             state_q, state_d;
    logic [MW-1:0]      owner_q, owner_d;
    logic [MW-1:0]      ptr_q, ptr_d;
    logic [SW-1:0]      sel_q, sel_d;
    logic               err_q, err_d;
    logic               we_q, we_d;
    logic [31:0]        adr_q, adr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [N_MST-1:0]   gnt_q, gnt_d;

    logic [N_MST-1:0]   arb_gnt;
    logic [MW-1:0]      win;
    logic [31:0]        win_adr;
    logic [31:0]        sel_full;
    logic               rv;

    rr_arbiter #(.N(N_MST), .PW(MW)) u_arb (
        .req (m_req),
        .ptr (ptr_q),
        .gnt (arb_gnt)
    );

    always_comb begin
        win = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (arb_gnt[i]) win = MW'(i);
        end
    end

    assign win_adr  = m_adr[32*int'(win) +: 32];
    assign sel_full = win_adr >> SEL_LSB;

    // Completion waits until the grant pulse is gone, so a decode error
    // reports one cycle after its grant rather than alongside it.
    assign rv = (state_q == ST_RESP) && (gnt_q == '0);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        err_d   = err_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (|m_req) begin
                    gnt_d   = arb_gnt;
                    owner_d = win;
                    ptr_d   = (win == MW'(N_MST - 1)) ? '0 : win + MW'(1);
                    we_d    = m_we[win];
                    adr_d   = win_adr;
                    wdata_d = m_wdata[DW*int'(win) +: DW];
                    cnt_d   = '0;
                    if (sel_full < 32'(N_SLV)) begin
                        sel_d   = SW'(sel_full);
                        err_d   = FALSE;
                        state_d = ST_BUSY;
                    end else begin
                        err_d   = TRUE;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                if (s_ready[sel_q]) begin
                    rdata_d = we_q ? '0 : s_rdata[DW*int'(sel_q) +: DW];
                    state_d = ST_RESP;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    err_d   = TRUE;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (rv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            err_q   <= FALSE;
            we_q    <= FALSE;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign m_gnt    = gnt_q;
    assign m_rvalid = rv ? (N_MST'(1) << owner_q) : '0;
    assign m_err    = rv & err_q;
    assign m_rdata  = rdata_q;
    assign s_req    = (state_q == ST_BUSY) ? (N_SLV'(1) << sel_q) : '0;
    assign s_we     = we_q;
    assign s_adr    = adr_q;
    assign s_wdata  = wdata_q;

endmodule

// File: tb/tb_sys_bus_ic.sv
// Directed bench for sys_bus_ic: read, decode error, contention,
// timeout, wait states and reset mid-transaction.
module tb_sys_bus_ic;

    logic         clk;
    logic         rst_n;
    logic [1:0]   m_req;
    logic [1:0]   m_we;
    logic [63:0]  m_adr;
    logic [63:0]  m_wdata;
    logic [1:0]   m_gnt;
    logic [1:0]   m_rvalid;
    logic [31:0]  m_rdata;
    logic         m_err;
    logic [3:0]   s_req;
    logic         s_we;
    logic [31:0]  s_adr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;

    int checks = 0;
    int errors = 0;

    sys_bus_ic #(
        .N_MST(2), .N_SLV(4), .DW(32), .SEL_LSB(28), .TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_adr    (m_adr),
        .m_wdata  (m_wdata),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .m_err    (m_err),
        .s_req    (s_req),
        .s_we     (s_we),
        .s_adr    (s_adr),
        .s_wdata  (s_wdata),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog sim time expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output logic [1:0] g, output int n);
        g = '0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (m_gnt != 2'b00) begin
                g = m_gnt;
                return;
            end
        end
        chk("gnt_wait_expired", 64'(m_gnt), 64'h1);
    endtask

    logic [1:0] g;
    int         n;

    initial begin
        rst_n   = 1'b0;
        m_req   = '0;
        m_we    = '0;
        m_adr   = '0;
        m_wdata = '0;
        s_ready = '0;
        s_rdata = '0;
        step();
        step();
        chk("rst_gnt", 64'(m_gnt), 64'h0);
        chk("rst_rvalid", 64'(m_rvalid), 64'h0);
        chk("rst_err", 64'(m_err), 64'h0);
        chk("rst_rdata", 64'(m_rdata), 64'h0);
        chk("rst_sreq", 64'(s_req), 64'h0);
        chk("rst_sadr", 64'(s_adr), 64'h0);
        rst_n = 1'b1;
        step();

        // single read, master 0, slave 0 ready in cycle 1
        m_req         = 2'b01;
        m_adr[31:0]   = 32'h0000_0010;
        step();
        chk("rd_gnt", 64'(m_gnt), 64'h1);
        chk("rd_sreq", 64'(s_req), 64'h1);
        chk("rd_sadr", 64'(s_adr), 64'h10);
        chk("rd_swe", 64'(s_we), 64'h0);
        chk("rd_rvalid_c1", 64'(m_rvalid), 64'h0);
        m_req          = '0;
        s_ready        = 4'b0001;
        s_rdata[31:0]  = 32'hCAFE_F00D;
        step();
        chk("rd_rvalid", 64'(m_rvalid), 64'h1);
        chk("rd_rdata", 64'(m_rdata), 64'hCAFE_F00D);
        chk("rd_err", 64'(m_err), 64'h0);
        chk("rd_sreq_c2", 64'(s_req), 64'h0);
        s_ready = '0;
        step();
        chk("rd_rvalid_c3", 64'(m_rvalid), 64'h0);

        // decode error, master 1
        m_req         = 2'b10;
        m_adr[63:32]  = 32'h5000_0000;
        step();
        chk("de_gnt", 64'(m_gnt), 64'h2);
        chk("de_sreq_c1", 64'(s_req), 64'h0);
        chk("de_rvalid_c1", 64'(m_rvalid), 64'h0);
        m_req = '0;
        step();
        chk("de_rvalid", 64'(m_rvalid), 64'h2);
        chk("de_err", 64'(m_err), 64'h1);
        chk("de_rdata", 64'(m_rdata), 64'h0);
        chk("de_sreq_c2", 64'(s_req), 64'h0);
        step();
        chk("de_rvalid_c3", 64'(m_rvalid), 64'h0);
        chk("de_err_c3", 64'(m_err), 64'h0);

        // contention from a fresh pointer
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        m_adr          = {32'h0000_0200, 32'h0000_0100};
        s_rdata[31:0]  = 32'h5555_AAAA;
        s_ready        = 4'b0001;
        m_req          = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(g, n);
            chk("rr_gnt", 64'(g), (k % 2 == 0) ? 64'h1 : 64'h2);
            chk("rr_sadr", 64'(s_adr),
                (k % 2 == 0) ? 64'h100 : 64'h200);
            if (k > 0) chk("rr_gap", 64'(n), 64'd3);
            if (k == 3) m_req = '0;
        end
        step();
        chk("rr_rdata", 64'(m_rdata), 64'h5555_AAAA);
        step();
        step();
        s_ready = '0;

        // timeout, master 0 to slave 1, unselected slave 0 ready
        m_req        = 2'b01;
        m_adr[31:0]  = 32'h1000_0000;
        s_ready      = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk("to_sreq", 64'(s_req), 64'h2);
            chk("to_rvalid", 64'(m_rvalid), 64'h0);
            if (c == 1) begin
                chk("to_gnt", 64'(m_gnt), 64'h1);
                m_req = '0;
            end
        end
        step();
        chk("to_rvalid_end", 64'(m_rvalid), 64'h1);
        chk("to_err", 64'(m_err), 64'h1);
        chk("to_rdata", 64'(m_rdata), 64'h0);
        chk("to_sreq_end", 64'(s_req), 64'h0);
        s_ready = '0;
        step();

        // wait-state write, master 1 to slave 2
        m_req           = 2'b10;
        m_we            = 2'b10;
        m_adr[63:32]    = 32'h2000_0000;
        m_wdata[63:32]  = 32'h1234_5678;
        s_rdata[95:64]  = 32'hDEAD_BEEF;
        s_ready         = 4'b0010;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("ws_sreq", 64'(s_req), 64'h4);
            chk("ws_swdata", 64'(s_wdata), 64'h1234_5678);
            chk("ws_swe", 64'(s_we), 64'h1);
            chk("ws_rvalid", 64'(m_rvalid), 64'h0);
            if (c == 1) begin
                chk("ws_gnt", 64'(m_gnt), 64'h2);
                m_req = '0;
            end
            if (c == 5) s_ready = 4'b0100;
        end
        step();
        chk("ws_rvalid_end", 64'(m_rvalid), 64'h2);
        chk("ws_err", 64'(m_err), 64'h0);
        chk("ws_rdata", 64'(m_rdata), 64'h0);
        chk("ws_sreq_end", 64'(s_req), 64'h0);
        s_ready = '0;
        m_we    = '0;
        step();

        // reset in cycle 3 of a stalled write, master 0 to slave 3
        m_req          = 2'b01;
        m_we           = 2'b01;
        m_adr[31:0]    = 32'h3000_0000;
        m_wdata[31:0]  = 32'hA5A5_A5A5;
        step();
        m_req = '0;
        step();
        step();
        chk("mr_sreq_pre", 64'(s_req), 64'h8);
        rst_n = 1'b0;
        #1;
        chk("mr_sreq", 64'(s_req), 64'h0);
        chk("mr_sadr", 64'(s_adr), 64'h0);
        chk("mr_swe", 64'(s_we), 64'h0);
        chk("mr_swdata", 64'(s_wdata), 64'h0);
        chk("mr_gnt", 64'(m_gnt), 64'h0);
        chk("mr_rvalid", 64'(m_rvalid), 64'h0);
        chk("mr_err", 64'(m_err), 64'h0);
        chk("mr_rdata", 64'(m_rdata), 64'h0);
        m_we = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("mr_rvalid_hold", 64'(m_rvalid), 64'h0);
        end
        rst_n             = 1'b1;
        m_req             = 2'b10;
        m_adr[63:32]      = 32'h3000_0004;
        s_rdata[127:96]   = 32'h0BAD_BEEF;
        step();
        chk("mr_post_gnt", 64'(m_gnt), 64'h2);
        chk("mr_post_sadr", 64'(s_adr), 64'h3000_0004);
        m_req   = '0;
        s_ready = 4'b1000;
        step();
        chk("mr_post_rvalid", 64'(m_rvalid), 64'h2);
        chk("mr_post_rdata", 64'(m_rdata), 64'h0BAD_BEEF);
        chk("mr_post_err", 64'(m_err), 64'h0);
        s_ready = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
